// File: rtl/ss_sched_pkg.sv
// Shared types and sizing helpers for the start/done scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ss_sched_pkg;

    // Scheduler phases: arbitrate, pulse start, wait for engine, report done.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ss_state_e;

    // Default requester count and the matching index width.
    localparam int unsigned SS_N_REQ_DFLT = 4;
    localparam int unsigned SS_IDX_W      = $clog2(SS_N_REQ_DFLT);

    // Index width for an arbitrary requester count (never narrower than 1 bit).
    function automatic int unsigned ss_idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ss_rr_pick.sv
// Round-robin picker: first set request at or after ptr, with wrap-around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
// Ports: req_i request vector, ptr_i highest-priority index,
//        grant_o one-hot pick, idx_o picked index, vld_o any request present.
module ss_rr_pick
    import ss_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = ss_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   rot_idx;
    logic [IDX_W:0]     sum;

    always_comb begin
        // Rotate so that bit ptr_i lands at position 0.
        dbl     = {req_i, req_i} >> ptr_i;
        rot     = dbl[N_REQ-1:0];
        rot_idx = '0;
        vld_o   = 1'b0;
        // Downward scan leaves the lowest set bit in rot_idx.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rot_idx = IDX_W'(i);
                vld_o   = 1'b1;
            end
        end
        // Rotate back: (rot_idx + ptr) mod N_REQ.
        sum = {1'b0, rot_idx} + {1'b0, ptr_i};
        if (sum >= (IDX_W+1)'(N_REQ)) begin
            sum = sum - (IDX_W+1)'(N_REQ);
        end
        idx_o   = sum[IDX_W-1:0];
        grant_o = vld_o ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx_o) : '0;
    end

endmodule

// File: rtl/ss_start_sched.sv
// Round-robin scheduler sharing one start/done engine between N_REQ requesters.
// Latency: grant and start one cycle after a request is seen in IDLE; done one cycle after engine done.
// Backpressure: requests are held level until o_done; watchdog aborts a silent engine with o_err.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_req level requests;
//        o_grant one-hot owner; o_eng_start/i_eng_done engine handshake;
//        o_done/o_err completion pulse and timeout flag; o_busy not idle.
module ss_start_sched
    import ss_sched_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TO_W        = 16,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_eng_start,
    input  logic             i_eng_done,
    output logic [N_REQ-1:0] o_done,
    output logic             o_err,
    output logic             o_busy
);

    localparam int unsigned IDX_W = ss_idx_w(N_REQ);
    localparam bit          WD_EN = (TIMEOUT_CYC != 0);
    // Watchdog value in the final WAIT cycle before abort.
    localparam logic [TO_W-1:0] WD_LAST = WD_EN ? TO_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [TO_W-1:0] WD_MAX  = '1;

    ss_state_e        state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [TO_W-1:0]  wd_q, wd_d;
    logic             start_q, start_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;

    ss_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (i_req),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .vld_o   (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        start_d = 1'b0;
        done_d  = '0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_grant;
                    idx_d   = pick_idx;
                    start_d = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Engine done is deliberately not looked at here.
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_eng_done) begin
                    done_d  = grant_q;
                    state_d = ST_DONE;
                end else if (WD_EN && (wd_q == WD_LAST)) begin
                    done_d  = grant_q;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            ST_DONE: begin
                ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
            start_q <= 1'b0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_eng_start = start_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_ss_start_sched.sv
// Bench for the round-robin start/done scheduler.
// Latency: drives one step per clock, samples 1 time unit after each rising edge.
// Backpressure: engine response delay and timeouts come from directed and random stimulus.
module tb_ss_start_sched;

    localparam int N  = 4;
    localparam int TO = 5;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [N-1:0] i_req = '0;
    logic         i_eng_done = 1'b0;
    logic [N-1:0] o_grant;
    logic         o_eng_start;
    logic [N-1:0] o_done;
    logic         o_err;
    logic         o_busy;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    ss_start_sched #(
        .N_REQ       (N),
        .TO_W        (16),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req       (i_req),
        .o_grant     (o_grant),
        .o_eng_start (o_eng_start),
        .i_eng_done  (i_eng_done),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Reference arbitration: search ptr, ptr+1, ... with wrap-around.
    function automatic int ref_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, o_grant, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_err"}, o_err, 0);
        chk({tag, "_start"}, o_eng_start, 0);
    endtask

    // One transaction from IDLE. dly: WAIT cycle (1-based) in which the engine
    // answers; 0 or > TO means it never does before the watchdog fires.
    task automatic txn(input logic [N-1:0] req, input int dly, input bit drop, input bit hold_done);
        int         idx;
        logic [N-1:0] oh;
        bit         fin;
        bit         exp_err;
        idx = ref_pick(req, ptr_m);
        oh  = '0;
        oh[idx] = 1'b1;
        i_req = req;
        if (hold_done) i_eng_done = 1'b1;
        step();
        chk("start_grant", o_grant, oh);
        chk("start_pulse", o_eng_start, 1);
        chk("start_busy", o_busy, 1);
        chk("start_done", o_done, 0);
        if (drop) i_req = '0;
        fin = 1'b0;
        exp_err = 1'b0;
        for (int w = 1; w <= TO && !fin; w++) begin
            step();
            chk("wait_start", o_eng_start, 0);
            chk("wait_done", o_done, 0);
            chk("wait_grant", o_grant, oh);
            chk("wait_busy", o_busy, 1);
            if (hold_done || w == dly) begin
                fin = 1'b1;
                exp_err = 1'b0;
                i_eng_done = 1'b1;
            end else if (w == TO) begin
                fin = 1'b1;
                exp_err = 1'b1;
            end
        end
        step();
        if (!hold_done) i_eng_done = 1'b0;
        chk("done_pulse", o_done, oh);
        chk("done_err", o_err, exp_err);
        chk("done_busy", o_busy, 1);
        chk("done_grant", o_grant, oh);
        step();
        chk_idle("idle");
        ptr_m = (idx + 1) % N;
        if (hold_done) begin
            i_req = '0;
            step();
            chk_idle("held_done_idle");
            i_eng_done = 1'b0;
        end
    endtask

    initial begin
        // Reset state.
        #2;
        chk_idle("reset");
        step();
        step();
        i_rst_n = 1'b1;
        ptr_m = 0;
        step();
        chk_idle("post_reset");

        // Single request, engine answers in the 4th WAIT cycle.
        txn(4'b0100, 4, 1'b0, 1'b0);

        // Engine never answers: watchdog abort, then next requester served normally.
        txn(4'b0010, 0, 1'b0, 1'b0);
        txn(4'b0100, 2, 1'b0, 1'b0);

        // Done and expiry in the same WAIT cycle: done wins.
        txn(4'b1000, TO, 1'b0, 1'b0);

        // Reset during WAIT: outputs drop immediately, no done pulse.
        i_req = 4'b0010;
        step();
        step();
        step();
        chk("rst_pre_busy", o_busy, 1);
        i_rst_n = 1'b0;
        #1;
        chk_idle("rst_mid");
        step();
        chk_idle("rst_held");
        i_rst_n = 1'b1;
        i_req = '0;
        ptr_m = 0;
        step();
        chk_idle("rst_release");

        // Fairness with everyone requesting: 0,1,2,3,0.
        for (int k = 0; k < N + 1; k++) begin
            chk("fair_ptr_model", ptr_m, k % N);
            txn(4'b1111, 2, 1'b0, 1'b0);
        end

        // Engine done held high across IDLE and START.
        txn(4'b0001, 1, 1'b0, 1'b1);

        // Request withdrawn right after grant.
        txn(4'b1000, 3, 1'b1, 1'b0);

        // Idle with no request stays idle even if engine done toggles.
        i_req = '0;
        i_eng_done = 1'b1;
        step();
        chk_idle("idle_noreq");
        i_eng_done = 1'b0;
        step();
        chk_idle("idle_noreq2");

        // Random traffic.
        for (int t = 0; t < 60; t++) begin
            logic [N-1:0] rq;
            int           d;
            bit           dr;
            rq = N'($urandom_range(1, 15));
            d  = $urandom_range(1, TO + 3);
            dr = 1'($urandom_range(0, 1));
            txn(rq, d, dr, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                i_req = '0;
                step();
                chk_idle("rand_gap");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within limit");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/ss_start_sched.md
Name: ss_start_sched

Overview:
- Round-robin scheduler that shares one start/done engine (the SS processing core) between N_REQ requesters.
- Arbitrates level requests and issues a single-cycle start pulse to the engine.
- Waits for the engine's done, then returns a one-cycle done pulse to the granted requester.
- Contains a watchdog that aborts a transaction if done never arrives; sits directly between the requesting subsystems and the engine's start-detect front end.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- TO_W, 16, width of the watchdog counter.
- TIMEOUT_CYC, 1000, WAIT-state cycles before abort; 0 disables the watchdog.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  N_REQ  level request per requester; held until that requester's o_done.
- o_grant  out  N_REQ  one-hot owner of the current transaction; all-zero when idle.
- o_eng_start  out  1  one-cycle start pulse to the engine.
- i_eng_done  in  1  engine completion (pulse or level; sampled only in WAIT).
- o_done  out  N_REQ  one-cycle completion pulse to the granted requester.
- o_err  out  1  asserted together with o_done when the transaction ended by timeout.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; o_grant, o_eng_start, o_done, o_err and o_busy all 0; rr pointer=0 (requester 0 has first priority); watchdog=0. Reset mid-transaction abandons the transaction with no o_done pulse.
- FSM states: IDLE, START, WAIT, DONE. All outputs are registered.
- IDLE:
  - If any i_req bit is set, pick the first set bit searching from ptr upward with wrap-around (ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1).
  - Register the one-hot grant, go to START.
  - No request: stay in IDLE.
- START:
  - o_eng_start=1 for exactly this cycle; watchdog cleared; go to WAIT.
  - i_eng_done is ignored in this cycle, so a stale done asserted together with start is not accepted.
- WAIT:
  - i_eng_done=1 -> go to DONE with err=0.
  - Otherwise the watchdog increments. When TIMEOUT_CYC!=0 and the watchdog reaches TIMEOUT_CYC-1 in a cycle without done -> go to DONE with err=1.
  - Done and expiry in the same cycle: done wins, err=0.
- DONE:
  - o_done[granted]=1 and o_err=err for one cycle.
  - ptr <= granted index + 1, mod N_REQ.
  - o_grant clears on exit to IDLE.
- Latency:
  - Request seen in IDLE at cycle k -> o_grant from k+1, o_eng_start at k+1.
  - i_eng_done sampled at cycle d -> o_done at d+1.
  - Minimum transaction is 4 cycles; the scheduler always passes through IDLE between transactions.
- Boundary conditions:
  - A requester dropping i_req mid-transaction does not abort it; o_done still pulses.
  - i_eng_done in IDLE, START or DONE is ignored.
  - The watchdog saturates, never wraps; TIMEOUT_CYC must be < 2^TO_W.
  - o_grant is always one-hot or zero.
  - Fairness: with all requesters permanently requesting, grant order is 0,1,...,N_REQ-1,0,...

Decomposition:
- Package ss_sched_pkg holds the state enum type (IDLE/START/WAIT/DONE) and a localparam for the index width, $clog2(N_REQ).
- One sub-module, ss_rr_pick: purely combinational rotate / priority-encode / rotate-back picker.
  - Inputs: request vector and ptr.
  - Outputs: one-hot grant, index and valid.

Test Plan:
- Reset, then i_req=4'b0100 from cycle 2 -> o_grant=0100 and o_eng_start pulse at cycle 3; i_eng_done at cycle 7 -> o_done=0100 at cycle 8, o_err=0, o_busy falls at cycle 9.
- i_req=4'b1111 held; engine answers done 2 cycles after each start -> grant order 0001, 0010, 0100, 1000, 0001; one start per grant.
- i_eng_done held high across IDLE and START -> accepted only in the first WAIT cycle; no extra o_done pulses.
- TIMEOUT_CYC=5, engine never responds -> o_done and o_err pulse together 6 cycles after the start pulse; next requester is served normally.
- i_rst_n driven low during WAIT -> all outputs 0 immediately, no o_done; after release, requester 0 is granted first.
- i_req withdrawn the cycle after grant -> transaction completes; o_done still pulses for that requester.
